game_turn_ctrl: RTL

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

---
 rtl/game_turn_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/game_turn_ctrl.sv
// Turn controller for a two-player networked battleship game.
// Sequences placement, ready handshake, shooting, defending and game end.
module game_turn_ctrl #(
    parameter int SHIPS   = 10,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       is_host,
    input  logic       btn_pick,
    input  logic [7:0] mouse_pos,
    input  logic [3:0] ship_count,
    input  logic [1:0] board_msg,
    input  logic       rx_valid,
    input  logic [1:0] rx_type,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [1:0] tx_type,
    output logic [7:0] tx_data,
    output logic       pick_ship,
    output logic       pick_place,
    output logic [7:0] check_addr,
    output logic       addr_received,
    output logic [1:0] msg_to_board,
    output logic [3:0] my_hits,
    output logic [3:0] enemy_hits,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [3:0] {
        PLACE, SYNC, AIM, SHOT_TX, WAIT_RES,
        ENEMY, CHECK, REPLY, OVER
    } state_t;

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]  SHIPS_N  = 4'(SHIPS);

    localparam logic [1:0] T_SHOT = 2'b01;
    localparam logic [1:0] T_RES  = 2'b10;
    localparam logic [1:0] T_RDY  = 2'b11;
    localparam logic [1:0] R_HIT  = 2'b10;
    localparam logic [1:0] R_MISS = 2'b11;

    state_t         state;
    logic [7:0]     target;
    logic [TW-1:0]  tmo;
    logic           peer_rdy;

    logic           click_ok;
    logic           rx_shot;
    logic           rx_res;
    logic           rx_rdy;
    logic           tx_fire;
    logic [3:0]     my_next;
    logic [3:0]     enemy_next;

    assign click_ok   = btn_pick && (mouse_pos[7:4] <= 4'd9)
                                 && (mouse_pos[3:0] <= 4'd9);
    assign rx_shot    = rx_valid && (rx_type == T_SHOT);
    assign rx_res     = rx_valid && (rx_type == T_RES);
    assign rx_rdy     = rx_valid && (rx_type == T_RDY);
    assign tx_fire    = tx_valid && tx_ready;
    assign my_next    = (my_hits == 4'hF) ? my_hits : my_hits + 4'd1;
    assign enemy_next = (enemy_hits == 4'hF) ? enemy_hits : enemy_hits + 4'd1;

    // Aiming cursor is live from target selection until the result lands.
    assign pick_place = (state == AIM) || (state == SHOT_TX)
                     || (state == WAIT_RES);

    // Result is forwarded to the guest board in the cycle it arrives.
    assign msg_to_board = (state == WAIT_RES && rx_res) ? rx_data[1:0] : 2'b00;

    // Main turn sequencer with registered frame and board outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLACE;
            target        <= '0;
            tmo           <= '0;
            peer_rdy      <= 1'b0;
            tx_valid      <= 1'b0;
            tx_type       <= 2'b00;
            tx_data       <= 8'h00;
            pick_ship     <= 1'b0;
            check_addr    <= 8'h00;
            addr_received <= 1'b0;
            my_hits       <= 4'd0;
            enemy_hits    <= 4'd0;
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            pick_ship     <= 1'b0;
            addr_received <= 1'b0;
            if ((state == PLACE || state == SYNC) && rx_rdy) begin
                peer_rdy <= 1'b1;
            end
            unique case (state)
                PLACE: begin
                    if (ship_count >= SHIPS_N) begin
                        tx_valid <= 1'b1;
                        tx_type  <= T_RDY;
                        tx_data  <= 8'h00;
                        state    <= SYNC;
                    end else if (click_ok) begin
                        pick_ship <= 1'b1;
                    end
                end
                SYNC: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                    end
                    if ((tx_fire || !tx_valid) && (peer_rdy || rx_rdy)) begin
                        state <= is_host ? AIM : ENEMY;
                    end
                end
                AIM: begin
                    if (click_ok) begin
                        target   <= mouse_pos;
                        tx_valid <= 1'b1;
                        tx_type  <= T_SHOT;
                        tx_data  <= mouse_pos;
                        state    <= SHOT_TX;
                    end
                end
                SHOT_TX: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        tmo      <= '0;
                        state    <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (rx_res) begin
                        unique case (rx_data[1:0])
                            R_HIT: begin
                                my_hits <= my_next;
                                if (my_next == SHIPS_N) begin
                                    game_over <= 1'b1;
                                    win       <= 1'b1;
                                    state     <= OVER;
                                end else begin
                                    state <= AIM;
                                end
                            end
                            R_MISS:  state <= ENEMY;
                            2'b00:   state <= AIM;
                            default: ;
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        tx_valid <= 1'b1;
                        tx_type  <= T_SHOT;
                        tx_data  <= target;
                        state    <= SHOT_TX;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ENEMY: begin
                    if (rx_shot) begin
                        check_addr    <= rx_data;
                        addr_received <= 1'b1;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (!addr_received) begin
                        tx_valid <= 1'b1;
                        tx_type  <= T_RES;
                        tx_data  <= {6'b0, board_msg};
                        state    <= REPLY;
                    end
                end
                REPLY: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        unique case (tx_data[1:0])
                            R_HIT: begin
                                enemy_hits <= enemy_next;
                                if (enemy_next == SHIPS_N) begin
                                    game_over <= 1'b1;
                                    win       <= 1'b0;
                                    state     <= OVER;
                                end else begin
                                    state <= ENEMY;
                                end
                            end
                            R_MISS:  state <= AIM;
                            default: state <= ENEMY;
                        endcase
                    end
                end
                OVER: ;
                default: state <= PLACE;
            endcase
        end
    end

endmodule
